// File: rtl/video_term_pkg.sv
// Shared widths, cursor glyph code and default raster timing for the terminal video path.
// CURSOR_BLINK_EN adds the blink-rate default.
package video_term_pkg;

  localparam int CHAR_CODE_W = 6;
  localparam int SCANLINE_W  = 3;
  localparam logic [CHAR_CODE_W-1:0] CURSOR_CODE = 6'h00;

  localparam int DOT_W  = 3;
  localparam int CELL_W = 7;
  localparam int LINE_W = 9;
  localparam int ADDR_W = 10;

  localparam int unsigned DEF_CHAR_W       = 7;
  localparam int unsigned DEF_H_CHARS      = 40;
  localparam int unsigned DEF_V_ROWS       = 24;
  localparam int unsigned DEF_H_TOTAL      = 65;
  localparam int unsigned DEF_H_SYNC_START = 48;
  localparam int unsigned DEF_H_SYNC_LEN   = 5;
  localparam int unsigned DEF_V_TOTAL      = 262;
  localparam int unsigned DEF_V_SYNC_START = 224;
  localparam int unsigned DEF_V_SYNC_LEN   = 3;
`ifdef CURSOR_BLINK_EN
  localparam int unsigned DEF_BLINK_FRAMES = 16;
  localparam int BLINK_W = 6;
`endif

  function automatic logic in_window(input int unsigned v, input int unsigned start,
                                     input int unsigned len);
    return (v >= start) && (v < start + len);
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Dot/cell/line counters, text row base address and sync/active decode.
// CURSOR_BLINK_EN adds a frame_end strobe for the cursor blink counter.
module video_timing_gen
  import video_term_pkg::*;
#(
  parameter int unsigned CHAR_W       = DEF_CHAR_W,
  parameter int unsigned H_CHARS      = DEF_H_CHARS,
  parameter int unsigned V_ROWS       = DEF_V_ROWS,
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
`ifdef CURSOR_BLINK_EN
  output logic                  frame_end,
`endif
  input  logic                  clk,
  input  logic                  clr_n,
  output logic [DOT_W-1:0]      dot,
  output logic [SCANLINE_W-1:0] scan,
  output logic [ADDR_W-1:0]     cell_addr,
  output logic                  active,
  output logic                  hsync_on,
  output logic                  vsync_on
);

  logic [DOT_W-1:0]  dot_q, dot_d;
  logic [CELL_W-1:0] cell_q, cell_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic dot_last, cell_last, line_last;

  assign dot_last  = (32'(dot_q) == CHAR_W - 1);
  assign cell_last = (32'(cell_q) == H_TOTAL - 1);
  assign line_last = (32'(line_q) == V_TOTAL - 1);

  always_comb begin
    dot_d      = dot_last ? '0 : dot_q + 1'b1;
    cell_d     = cell_q;
    line_d     = line_q;
    row_base_d = row_base_q;
    if (dot_last) begin
      if (cell_last) begin
        cell_d = '0;
        if (line_last) begin
          line_d     = '0;
          row_base_d = '0;
        end else begin
          line_d = line_q + 1'b1;
          // advance only when the next line starts a new active text row
          if ((line_q[2:0] == 3'd7) && (32'(line_q) < V_ROWS * 8 - 1))
            row_base_d = row_base_q + ADDR_W'(H_CHARS);
        end
      end else begin
        cell_d = cell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dot_q      <= '0;
      cell_q     <= '0;
      line_q     <= '0;
      row_base_q <= '0;
    end else begin
      dot_q      <= dot_d;
      cell_q     <= cell_d;
      line_q     <= line_d;
      row_base_q <= row_base_d;
    end
  end

  assign dot       = dot_q;
  assign scan      = line_q[2:0];
  assign cell_addr = row_base_q + ADDR_W'(cell_q);
  assign active    = (32'(cell_q) < H_CHARS) && (32'(line_q) < V_ROWS * 8);
  assign hsync_on  = in_window(32'(cell_q), H_SYNC_START, H_SYNC_LEN);
  assign vsync_on  = in_window(32'(line_q), V_SYNC_START, V_SYNC_LEN);
`ifdef CURSOR_BLINK_EN
  assign frame_end = dot_last && cell_last && line_last;
`endif

endmodule

// File: rtl/char_pixel_fetch.sv
// Glyph fetch pipeline feeding the parallel-load dot shift register, plus cursor substitution.
// CURSOR_BLINK_EN: cursor glyph shown only during alternate BLINK_FRAMES-frame phases.
module char_pixel_fetch
  import video_term_pkg::*;
#(
  parameter int unsigned CHAR_W       = DEF_CHAR_W,
  parameter int unsigned H_CHARS      = DEF_H_CHARS,
  parameter int unsigned V_ROWS       = DEF_V_ROWS,
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN
`ifdef CURSOR_BLINK_EN
  , parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
`endif
) (
  input  logic                             clk,
  input  logic                             clr_n,
  output logic [ADDR_W-1:0]                scr_addr,
  input  logic [CHAR_CODE_W-1:0]           scr_data,
  output logic [CHAR_CODE_W+SCANLINE_W-1:0] rom_addr,
  input  logic [7:0]                       rom_data,
  input  logic [ADDR_W-1:0]                cursor_addr,
  output logic [7:0]                       sr_p,
  output logic                             sr_load_n,
  output logic                             hsync_n,
  output logic                             vsync_n,
  output logic                             blank
);

  localparam logic [DOT_W-1:0] DOT_SCR  = DOT_W'(0);
  localparam logic [DOT_W-1:0] DOT_ROM  = DOT_W'(1);
  localparam logic [DOT_W-1:0] DOT_PAT  = DOT_W'(2);
  localparam logic [DOT_W-1:0] DOT_LOAD = DOT_W'(CHAR_W - 1);

  logic [DOT_W-1:0]      dot;
  logic [SCANLINE_W-1:0] scan;
  logic [ADDR_W-1:0]     cell_addr;
  logic active, hsync_on, vsync_on, cursor_on;

  logic [ADDR_W-1:0]                 scr_addr_q, scr_addr_d;
  logic [CHAR_CODE_W+SCANLINE_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0] pattern_q, pattern_d, sr_p_q, sr_p_d;
  logic sr_load_n_q, sr_load_n_d, hsync_n_q, hsync_n_d;
  logic vsync_n_q, vsync_n_d, blank_q, blank_d;

`ifdef CURSOR_BLINK_EN
  logic frame_end;
`endif

  video_timing_gen #(
    .CHAR_W(CHAR_W), .H_CHARS(H_CHARS), .V_ROWS(V_ROWS), .H_TOTAL(H_TOTAL),
    .H_SYNC_START(H_SYNC_START), .H_SYNC_LEN(H_SYNC_LEN), .V_TOTAL(V_TOTAL),
    .V_SYNC_START(V_SYNC_START), .V_SYNC_LEN(V_SYNC_LEN)
  ) u_timing (
`ifdef CURSOR_BLINK_EN
    .frame_end(frame_end),
`endif
    .clk(clk), .clr_n(clr_n), .dot(dot), .scan(scan), .cell_addr(cell_addr),
    .active(active), .hsync_on(hsync_on), .vsync_on(vsync_on)
  );

`ifdef CURSOR_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (32'(blink_cnt_q) == BLINK_FRAMES - 1) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign cursor_on = active && (scr_addr_q == cursor_addr) && blink_phase_q;
`else
  // scr_addr_q still holds this cell's address while the ROM fetch is issued
  assign cursor_on = active && (scr_addr_q == cursor_addr);
`endif

  always_comb begin
    scr_addr_d  = scr_addr_q;
    rom_addr_d  = rom_addr_q;
    pattern_d   = pattern_q;
    sr_p_d      = sr_p_q;
    sr_load_n_d = 1'b1;
    hsync_n_d   = hsync_n_q;
    vsync_n_d   = vsync_n_q;
    blank_d     = blank_q;
    case (dot)
      DOT_SCR: if (active) scr_addr_d = cell_addr;
      DOT_ROM: rom_addr_d = {(cursor_on ? CURSOR_CODE : scr_data), scan};
      DOT_PAT: pattern_d = active ? rom_data : 8'h00;
      DOT_LOAD: begin
        // sync/blank move with the load so they track the pixels being shifted
        sr_p_d      = pattern_q;
        sr_load_n_d = 1'b0;
        hsync_n_d   = ~hsync_on;
        vsync_n_d   = ~vsync_on;
        blank_d     = ~active;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      scr_addr_q  <= '0;
      rom_addr_q  <= '0;
      pattern_q   <= '0;
      sr_p_q      <= '0;
      sr_load_n_q <= 1'b1;
      hsync_n_q   <= 1'b1;
      vsync_n_q   <= 1'b1;
      blank_q     <= 1'b1;
    end else begin
      scr_addr_q  <= scr_addr_d;
      rom_addr_q  <= rom_addr_d;
      pattern_q   <= pattern_d;
      sr_p_q      <= sr_p_d;
      sr_load_n_q <= sr_load_n_d;
      hsync_n_q   <= hsync_n_d;
      vsync_n_q   <= vsync_n_d;
      blank_q     <= blank_d;
    end
  end

  assign scr_addr  = scr_addr_q;
  assign rom_addr  = rom_addr_q;
  assign sr_p      = sr_p_q;
  assign sr_load_n = sr_load_n_q;
  assign hsync_n   = hsync_n_q;
  assign vsync_n   = vsync_n_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_char_pixel_fetch.sv
// Directed bench: dut_a uses default timing, dut_b a short 20-line frame for vertical checks.
module tb_char_pixel_fetch;

  logic clk = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;
  int total = 0;
  int bad = 0;

  logic [5:0] scr_mem [1024];
  logic [7:0] rom_mem [512];

  logic [9:0] scr_addr_a, scr_addr_b, cur_a, cur_b;
  logic [5:0] scr_data_a, scr_data_b;
  logic [8:0] rom_addr_a, rom_addr_b;
  logic [7:0] rom_data_a, rom_data_b, sr_p_a, sr_p_b;
  logic ld_a, ld_b, hs_a, hs_b, vs_a, vs_b, bl_a, bl_b;

  assign scr_data_a = scr_mem[scr_addr_a];
  assign scr_data_b = scr_mem[scr_addr_b];
  assign rom_data_a = rom_mem[rom_addr_a];
  assign rom_data_b = rom_mem[rom_addr_b];

  always #5 clk = ~clk;

  char_pixel_fetch dut_a (
    .clk(clk), .clr_n(clr_a), .scr_addr(scr_addr_a), .scr_data(scr_data_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .cursor_addr(cur_a),
    .sr_p(sr_p_a), .sr_load_n(ld_a), .hsync_n(hs_a), .vsync_n(vs_a), .blank(bl_a)
  );

  char_pixel_fetch #(
    .V_ROWS(2), .V_TOTAL(20), .V_SYNC_START(17), .V_SYNC_LEN(2)
`ifdef CURSOR_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut_b (
    .clk(clk), .clr_n(clr_b), .scr_addr(scr_addr_b), .scr_data(scr_data_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .cursor_addr(cur_b),
    .sr_p(sr_p_b), .sr_load_n(ld_b), .hsync_n(hs_b), .vsync_n(vs_b), .blank(bl_b)
  );

  // after return, the next rising edge is edge 0 (dot 0, cell 0, line 0)
  task automatic restart_a();
    clr_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr_a = 1'b1;
  endtask

  task automatic restart_b();
    clr_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr_b = 1'b1;
  endtask

  task automatic test_reset();
    clr_a = 1'b0;
    clr_b = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (scr_addr_a !== 10'd0) begin bad++; $display("FAIL rst_scr_addr got=%0h want=0", scr_addr_a); end
    total++; if (rom_addr_a !== 9'd0) begin bad++; $display("FAIL rst_rom_addr got=%0h want=0", rom_addr_a); end
    total++; if (sr_p_a !== 8'h00) begin bad++; $display("FAIL rst_sr_p got=%0h want=0", sr_p_a); end
    total++; if (ld_a !== 1'b1) begin bad++; $display("FAIL rst_sr_load_n got=%b want=1", ld_a); end
    total++; if (hs_a !== 1'b1) begin bad++; $display("FAIL rst_hsync_n got=%b want=1", hs_a); end
    total++; if (vs_a !== 1'b1) begin bad++; $display("FAIL rst_vsync_n got=%b want=1", vs_a); end
    total++; if (bl_a !== 1'b1) begin bad++; $display("FAIL rst_blank got=%b want=1", bl_a); end
    total++; if (ld_b !== 1'b1 || bl_b !== 1'b1) begin bad++; $display("FAIL rst_b ld=%b blank=%b want=1/1", ld_b, bl_b); end
  endtask

  task automatic test_release();
    int first_low = -1;
    cur_a = 10'd960;
    restart_a();
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      if (ld_a === 1'b0 && first_low < 0) first_low = k;
      if (k == 1) begin
        total++; if (rom_addr_a !== 9'h028) begin bad++; $display("FAIL rel_rom_addr got=%0h want=28", rom_addr_a); end
      end
    end
    total++; if (first_low != 6) begin bad++; $display("FAIL rel_first_load got=%0d want=6", first_low); end
    total++; if (sr_p_a !== 8'h79) begin bad++; $display("FAIL rel_sr_p got=%0h want=79", sr_p_a); end
    total++; if (bl_a !== 1'b0) begin bad++; $display("FAIL rel_blank got=%b want=0", bl_a); end
  endtask

  task automatic test_one_line();
    int loads = 0, bad_phase = 0, hs_low = 0, hs_first = -1, bl_low = 0, vs_low = 0;
    cur_a = 10'd960;
    restart_a();
    for (int k = 0; k < 455; k++) begin
      @(posedge clk); #1;
      if (ld_a === 1'b0) loads++;
      if ((ld_a === 1'b0) != ((k % 7) == 6)) bad_phase++;
      if (hs_a === 1'b0) begin hs_low++; if (hs_first < 0) hs_first = k; end
      if (bl_a === 1'b0) bl_low++;
      if (vs_a === 1'b0) vs_low++;
      if (k == 7) begin
        total++; if (scr_addr_a !== 10'd1) begin bad++; $display("FAIL line_scr_addr_c1 got=%0d want=1", scr_addr_a); end
      end
      if (k == 13) begin
        total++; if (sr_p_a !== 8'hA5) begin bad++; $display("FAIL line_sr_p_c1 got=%0h want=a5", sr_p_a); end
      end
    end
    total++; if (loads != 65) begin bad++; $display("FAIL line_loads got=%0d want=65", loads); end
    total++; if (bad_phase != 0) begin bad++; $display("FAIL line_load_phase got=%0d want=0", bad_phase); end
    total++; if (hs_low != 35) begin bad++; $display("FAIL line_hs_len got=%0d want=35", hs_low); end
    total++; if (hs_first != 342) begin bad++; $display("FAIL line_hs_start got=%0d want=342", hs_first); end
    total++; if (bl_low != 280) begin bad++; $display("FAIL line_blank_low got=%0d want=280", bl_low); end
    total++; if (vs_low != 0) begin bad++; $display("FAIL line_vs got=%0d want=0", vs_low); end
  endtask

  task automatic test_row_addr();
    cur_a = 10'd960;
    restart_a();
    for (int k = 0; k <= 4103; k++) begin
      @(posedge clk); #1;
      if (k == 3458) begin
        total++; if (scr_addr_a !== 10'd39) begin bad++; $display("FAIL row_l7c39 got=%0d want=39", scr_addr_a); end
      end
      if (k == 3647) begin
        total++; if (scr_addr_a !== 10'd41) begin bad++; $display("FAIL row_l8c1 got=%0d want=41", scr_addr_a); end
      end
      if (k == 3648) begin
        total++; if (rom_addr_a !== 9'd8) begin bad++; $display("FAIL row_rom_l8c1 got=%0d want=8", rom_addr_a); end
      end
      if (k == 3653) begin
        total++; if (sr_p_a !== 8'hA5) begin bad++; $display("FAIL row_sr_p_l8c1 got=%0h want=a5", sr_p_a); end
      end
      if (k == 3920) begin
        total++; if (scr_addr_a !== 10'd79) begin bad++; $display("FAIL row_hold_c40 got=%0d want=79", scr_addr_a); end
      end
      if (k == 3926) begin
        total++; if (sr_p_a !== 8'h00) begin bad++; $display("FAIL row_inactive_pat got=%0h want=0", sr_p_a); end
      end
      if (k == 4103) begin
        total++; if (rom_addr_a !== 9'd9) begin bad++; $display("FAIL row_rom_l9c1 got=%0d want=9", rom_addr_a); end
      end
    end
  endtask

  task automatic test_cursor();
    cur_a = 10'd0;
    restart_a();
    for (int k = 0; k <= 456; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        total++; if (rom_addr_a !== 9'd0) begin bad++; $display("FAIL cur_rom_c0 got=%0h want=0", rom_addr_a); end
      end
      if (k == 6) begin
        total++; if (sr_p_a !== 8'h01) begin bad++; $display("FAIL cur_sr_p_c0 got=%0h want=1", sr_p_a); end
      end
      if (k == 8) begin
        total++; if (rom_addr_a !== 9'd8) begin bad++; $display("FAIL cur_rom_c1 got=%0h want=8", rom_addr_a); end
      end
      if (k == 456) begin
        total++; if (rom_addr_a !== 9'd1) begin bad++; $display("FAIL cur_rom_l1c0 got=%0h want=1", rom_addr_a); end
      end
    end
    cur_a = 10'd960;
  endtask

  task automatic test_reset_midline();
    int loads = 0;
    cur_a = 10'd960;
    restart_a();
    for (int k = 0; k <= 13; k++) begin
      @(posedge clk); #1;
    end
    clr_a = 1'b0;
    #1;
    total++; if (ld_a !== 1'b1) begin bad++; $display("FAIL mid_sr_load_n got=%b want=1", ld_a); end
    total++; if (sr_p_a !== 8'h00) begin bad++; $display("FAIL mid_sr_p got=%0h want=0", sr_p_a); end
    total++; if (bl_a !== 1'b1) begin bad++; $display("FAIL mid_blank got=%b want=1", bl_a); end
    total++; if (scr_addr_a !== 10'd0 || rom_addr_a !== 9'd0) begin bad++; $display("FAIL mid_addr got=%0h/%0h want=0/0", scr_addr_a, rom_addr_a); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ld_a === 1'b0) loads++;
    end
    total++; if (loads != 0) begin bad++; $display("FAIL mid_no_load got=%0d want=0", loads); end
  endtask

  task automatic test_frame();
    int vs_low = 0, vs_first = -1, bl_bad = 0, hs_low18 = 0;
    cur_b = 10'd960;
    restart_b();
    for (int k = 0; k <= 9106; k++) begin
      @(posedge clk); #1;
      if (vs_b === 1'b0) begin vs_low++; if (vs_first < 0) vs_first = k; end
      if (k >= 7286 && k <= 9105 && bl_b !== 1'b1) bl_bad++;
      if (k >= 18 * 455 && k < 19 * 455 && hs_b === 1'b0) hs_low18++;
      if (k == 6831) begin
        total++; if (bl_b !== 1'b0) begin bad++; $display("FAIL frm_blank_l15 got=%b want=0", bl_b); end
      end
      if (k == 9099) begin
        total++; if (scr_addr_b !== 10'd79) begin bad++; $display("FAIL frm_scr_hold got=%0d want=79", scr_addr_b); end
      end
      if (k == 9100) begin
        total++; if (scr_addr_b !== 10'd0) begin bad++; $display("FAIL frm_wrap_scr got=%0d want=0", scr_addr_b); end
      end
      if (k == 9101) begin
        total++; if (rom_addr_b !== 9'h028) begin bad++; $display("FAIL frm_wrap_rom got=%0h want=28", rom_addr_b); end
      end
      if (k == 9106) begin
        total++; if (bl_b !== 1'b0) begin bad++; $display("FAIL frm_wrap_blank got=%b want=0", bl_b); end
      end
    end
    total++; if (vs_low != 910) begin bad++; $display("FAIL frm_vs_len got=%0d want=910", vs_low); end
    total++; if (vs_first != 7741) begin bad++; $display("FAIL frm_vs_start got=%0d want=7741", vs_first); end
    total++; if (bl_bad != 0) begin bad++; $display("FAIL frm_vblank got=%0d want=0", bl_bad); end
    total++; if (hs_low18 != 35) begin bad++; $display("FAIL frm_hs_in_vblank got=%0d want=35", hs_low18); end
  endtask

`ifdef CURSOR_BLINK_EN
  task automatic test_blink();
    cur_b = 10'd0;
    restart_b();
    for (int k = 0; k <= 18300; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 9101) begin
        total++; if (rom_addr_b[8:3] !== 6'd0) begin bad++; $display("FAIL blink_on k=%0d got=%0h want=0", k, rom_addr_b[8:3]); end
      end
      if (k == 18201) begin
        total++; if (rom_addr_b[8:3] !== 6'd5) begin bad++; $display("FAIL blink_off got=%0h want=5", rom_addr_b[8:3]); end
      end
    end
    restart_b();
    for (int k = 0; k <= 1; k++) begin
      @(posedge clk); #1;
    end
    total++; if (rom_addr_b[8:3] !== 6'd0) begin bad++; $display("FAIL blink_rst got=%0h want=0", rom_addr_b[8:3]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) scr_mem[i] = 6'((i % 7) + 2);
    scr_mem[0]  = 6'h05;
    scr_mem[1]  = 6'h01;
    scr_mem[41] = 6'h01;
    for (int i = 0; i < 512; i++) rom_mem[i] = 8'(i * 3 + 1);
    rom_mem[8] = 8'hA5;
    cur_a = 10'd960;
    cur_b = 10'd960;

    test_reset();
    test_release();
    test_one_line();
    test_row_addr();
    test_cursor();
    test_reset_midline();
    test_frame();
`ifdef CURSOR_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
